pcie_rd_completer: RTL and testbench

Downstream consumer of the PCIe receive decoder's read-request outputs. Each 2-DW memory read (`read_valid`, `address`, `rid_tag`) is queued and fetched from the user register space through a strobe/valid port. The block then returns a 3-DW-header CplD TLP with a 64-bit payload on the 64-bit AXI-stream transmit interface to the PCIe core. It is the only source of PIO read completions in the design.

---
 rtl/pcie_rd_completer.sv | 205 ++++++++++++++++++++
 tb/tb_pcie_rd_completer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_rd_completer.sv
// Small synchronous FIFO: WIDTH-bit entries, DEPTH entries (power of two).
// Latency: a pushed entry is visible at rdata on the cycle after the push edge.
// Backpressure: none internally; the caller never pushes when full (unless it pops too) and never pops when empty.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;

    // Pointer advance; the extra MSB tells full from empty and wraps naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // Pointer registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q[AW-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
endmodule

// PIO read completer: queues 2-DW reads, fetches the register, returns a 3-beat CplD.
// Latency: strobe 1 cycle after the request is queued; BEAT0 the cycle after read data; 5 cycles/completion min.
// Backpressure: beats hold stable while tready=0; requests queue up to FIFO_DEPTH, extras are dropped and flag overflow.
module pcie_rd_completer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        read_valid,
    input  logic [12:0] address,
    input  logic [23:0] rid_tag,
    input  logic [15:0] completer_id,
    output logic        rd_strobe,
    output logic [12:0] rd_addr,
    input  logic        rd_data_valid,
    input  logic [63:0] rd_data,
    output logic        tvalid,
    input  logic        tready,
    output logic [63:0] tdata,
    output logic [7:0]  tkeep,
    output logic        tlast,
    output logic        overflow
);
    localparam logic [31:0] CPLD_DW0 = 32'h4A00_0002;

    typedef enum logic [2:0] {IDLE, RD_WAIT, BEAT0, BEAT1, BEAT2} state_t;

    state_t      state_q, state_d;
    logic [3:0]  req_alo_q, req_alo_d;    // address[3:0], all the header needs
    logic [23:0] req_tag_q, req_tag_d;
    logic [63:0] data_q, data_d;
    logic        rd_strobe_q, rd_strobe_d;
    logic [12:0] rd_addr_q, rd_addr_d;
    logic        tvalid_q, tvalid_d;
    logic [63:0] tdata_q, tdata_d;
    logic [7:0]  tkeep_q, tkeep_d;
    logic        tlast_q, tlast_d;
    logic        overflow_q, overflow_d;

    logic        q_push, q_pop, q_full, q_empty;
    logic [36:0] q_head;
    logic [31:0] dw1, dw2;

    fifo #(.WIDTH(37), .DEPTH(FIFO_DEPTH)) u_req_fifo (
        .clock (clock),
        .reset (reset),
        .push  (q_push),
        .pop   (q_pop),
        .wdata ({address, rid_tag}),
        .rdata (q_head),
        .full  (q_full),
        .empty (q_empty)
    );

    // Host order is little-endian; each payload DW goes out byte-reversed.
    function automatic logic [31:0] swap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    assign dw1 = {completer_id, 3'b000, 1'b0, 12'd8};
    assign dw2 = {req_tag_q[23:8], req_tag_q[7:0], 1'b0, req_alo_q, 3'b000};

    // Next-state, queue control and next values of every registered output.
    always_comb begin
        state_d     = state_q;
        req_alo_d   = req_alo_q;
        req_tag_d   = req_tag_q;
        data_d      = data_q;
        rd_strobe_d = 1'b0;
        rd_addr_d   = rd_addr_q;
        tvalid_d    = tvalid_q;
        tdata_d     = tdata_q;
        tkeep_d     = tkeep_q;
        tlast_d     = tlast_q;
        q_pop       = 1'b0;
        case (state_q)
            IDLE: if (!q_empty) begin
                q_pop       = 1'b1;
                req_alo_d   = q_head[27:24];
                req_tag_d   = q_head[23:0];
                rd_strobe_d = 1'b1;
                rd_addr_d   = q_head[36:24];
                state_d     = RD_WAIT;
            end
            RD_WAIT: if (rd_data_valid) begin
                data_d   = rd_data;
                tvalid_d = 1'b1;
                tdata_d  = {dw1, CPLD_DW0};
                tkeep_d  = 8'hFF;
                tlast_d  = 1'b0;
                state_d  = BEAT0;
            end
            BEAT0: if (tready) begin
                tdata_d = {swap32(data_q[31:0]), dw2};
                state_d = BEAT1;
            end
            BEAT1: if (tready) begin
                tdata_d = {32'h0, swap32(data_q[63:32])};
                tkeep_d = 8'h0F;
                tlast_d = 1'b1;
                state_d = BEAT2;
            end
            BEAT2: if (tready) begin
                tvalid_d = 1'b0;
                tdata_d  = '0;
                tkeep_d  = '0;
                tlast_d  = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A pop in the same cycle frees the slot, so a full queue still accepts.
        q_push     = read_valid && (!q_full || q_pop);
        overflow_d = overflow_q | (read_valid && q_full && !q_pop);
    end

    // State and output registers; reset discards the in-flight TLP at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            req_alo_q   <= '0;
            req_tag_q   <= '0;
            data_q      <= '0;
            rd_strobe_q <= 1'b0;
            rd_addr_q   <= '0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tlast_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_alo_q   <= req_alo_d;
            req_tag_q   <= req_tag_d;
            data_q      <= data_d;
            rd_strobe_q <= rd_strobe_d;
            rd_addr_q   <= rd_addr_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            tlast_q     <= tlast_d;
            overflow_q  <= overflow_d;
        end
    end

    assign rd_strobe = rd_strobe_q;
    assign rd_addr   = rd_addr_q;
    assign tvalid    = tvalid_q;
    assign tdata     = tdata_q;
    assign tkeep     = tkeep_q;
    assign tlast     = tlast_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_pcie_rd_completer.sv
// Bench for pcie_rd_completer: directed scenarios plus random traffic against a queue model.
// Latency: the model predicts strobe/beat timing per cycle; outputs are sampled on the falling edge.
// Backpressure: tready is driven by fixed patterns and randomly; held beats must not change.
module tb_pcie_rd_completer;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        read_valid = 1'b0;
    logic [12:0] address = '0;
    logic [23:0] rid_tag = '0;
    logic [15:0] completer_id = 16'h0100;
    logic        rd_strobe;
    logic [12:0] rd_addr;
    logic        rd_data_valid = 1'b0;
    logic [63:0] rd_data = '0;
    logic        tvalid;
    logic        tready = 1'b0;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        overflow;

    pcie_rd_completer #(.FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .read_valid(read_valid), .address(address),
        .rid_tag(rid_tag), .completer_id(completer_id), .rd_strobe(rd_strobe),
        .rd_addr(rd_addr), .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .tvalid(tvalid), .tready(tready), .tdata(tdata), .tkeep(tkeep),
        .tlast(tlast), .overflow(overflow)
    );

    always #5 clock = ~clock;

    typedef struct packed { logic [12:0] a; logic [23:0] t; } req_t;
    typedef struct packed { logic [63:0] d; logic [7:0] k; logic l; } beat_t;

    int tests = 0;
    int fails = 0;

    // Reference model: accepted-request queue, one completion in flight, beat counter.
    req_t        q[$];
    req_t        cur;
    logic [63:0] cur_data;
    logic        busy = 1'b0;
    int          beat_idx = 0;       // 0: no beat shown, 1..3: BEAT0..BEAT2 shown
    logic        exp_strobe = 1'b0;
    logic        ovf_exp = 1'b0;

    // Register-space responder.
    logic        pend = 1'b0;
    int          lat_cnt = 0;
    int          fixed_lat = 1;      // <0: random 0..3 cycles
    int          junk_pct = 0;
    logic        force_data = 1'b1;
    logic [63:0] fdata = 64'h1122_3344_5566_7788;

    // Accepted-beat log for directed literal checks.
    logic [63:0] acc_d[$];
    logic [7:0]  acc_k[$];
    logic        acc_l[$];
    logic [7:0]  tag_log[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    function automatic beat_t exp_beat(input int idx);
        beat_t       b;
        logic [31:0] h1, h2;
        h1 = {completer_id, 3'b000, 1'b0, 12'd8};
        h2 = {cur.t[23:8], cur.t[7:0], 1'b0, cur.a[3:0], 3'b000};
        case (idx)
            0:       b = '{d: {h1, 32'h4A00_0002}, k: 8'hFF, l: 1'b0};
            1:       b = '{d: {bswap(cur_data[31:0]), h2}, k: 8'hFF, l: 1'b0};
            default: b = '{d: {32'h0, bswap(cur_data[63:32])}, k: 8'h0F, l: 1'b1};
        endcase
        return b;
    endfunction

    // One clock cycle: check what the DUT shows, drive inputs, advance the model over the next edge.
    task automatic step(input logic rv, input logic [12:0] a, input logic [23:0] t, input logic rdy);
        logic  pop, dlv;
        beat_t b;
        @(negedge clock);
        chk("rd_strobe", rd_strobe, exp_strobe);
        if (exp_strobe) chk("rd_addr", rd_addr, cur.a);
        chk("tvalid", tvalid, beat_idx != 0);
        if (beat_idx != 0) begin
            b = exp_beat(beat_idx - 1);
            chk("tdata", tdata, b.d);
            chk("tkeep", tkeep, b.k);
            chk("tlast", tlast, b.l);
        end
        chk("overflow", overflow, ovf_exp);
        if (tvalid && rdy) begin
            acc_d.push_back(tdata);
            acc_k.push_back(tkeep);
            acc_l.push_back(tlast);
        end
        if (beat_idx == 2 && rdy) tag_log.push_back(tdata[15:8]);

        dlv = 1'b0;
        if (exp_strobe) begin
            pend    = 1'b1;
            lat_cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
        end
        if (pend && lat_cnt == 0) begin
            pend          = 1'b0;
            dlv           = 1'b1;
            rd_data_valid = 1'b1;
            rd_data       = force_data ? fdata : {$urandom, $urandom};
            cur_data      = rd_data;
        end else begin
            if (pend) lat_cnt--;
            rd_data_valid = !pend && (int'($urandom_range(0, 99)) < junk_pct);
            rd_data       = {$urandom, $urandom};
        end
        read_valid = rv;
        address    = a;
        rid_tag    = t;
        tready     = rdy;

        pop = !busy && (q.size() > 0);
        if (pop) begin
            cur  = q.pop_front();
            busy = 1'b1;
        end
        if (rv) begin
            if (q.size() < DEPTH) q.push_back('{a: a, t: t});
            else ovf_exp = 1'b1;
        end
        exp_strobe = pop;
        if (dlv) beat_idx = 1;
        else if (beat_idx != 0 && rdy) begin
            if (beat_idx == 3) begin
                beat_idx = 0;
                busy     = 1'b0;
            end else beat_idx++;
        end
    endtask

    task automatic run_idle(input int n, input logic rdy);
        repeat (n) step(1'b0, 13'h0, 24'h0, rdy);
    endtask

    task automatic wait_beat(input int target, input logic rdy);
        int n = 0;
        while (beat_idx != target && n < 40) begin
            step(1'b0, 13'h0, 24'h0, rdy);
            n++;
        end
    endtask

    task automatic clear_logs();
        acc_d.delete(); acc_k.delete(); acc_l.delete(); tag_log.delete();
    endtask

    // Compare the logged beats of one completion with the single-read literals.
    task automatic check_single(input string nm);
        logic [63:0] ed[3];
        logic [7:0]  ek[3];
        logic        el[3];
        ed[0] = {32'h0100_0008, 32'h4A00_0002};
        ed[1] = {32'h8877_6655, 32'h00A5_3C28};
        ed[2] = {32'h0000_0000, 32'h4433_2211};
        ek[0] = 8'hFF; ek[1] = 8'hFF; ek[2] = 8'h0F;
        el[0] = 1'b0;  el[1] = 1'b0;  el[2] = 1'b1;
        chk({nm, "_nbeats"}, 64'(acc_d.size()), 64'd3);
        while (acc_d.size() < 3) begin
            acc_d.push_back('x); acc_k.push_back('x); acc_l.push_back(1'bx);
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_data%0d", nm, i), acc_d[i], ed[i]);
            chk($sformatf("%s_keep%0d", nm, i), 64'(acc_k[i]), 64'(ek[i]));
            chk($sformatf("%s_last%0d", nm, i), 64'(acc_l[i]), 64'(el[i]));
        end
    endtask

    // Assert reset mid-cycle: every output must drop without waiting for an edge.
    task automatic do_reset();
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_tkeep", tkeep, 0);
        chk("rst_rd_strobe", rd_strobe, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_overflow", overflow, 0);
        q.delete();
        busy = 1'b0; beat_idx = 0; exp_strobe = 1'b0; ovf_exp = 1'b0; pend = 1'b0;
        read_valid = 1'b0; rd_data_valid = 1'b0; tready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        do_reset();

        // Single read, data one cycle after the strobe, tready held high.
        clear_logs();
        step(1'b1, 13'h0005, 24'h00A53C, 1'b1);
        run_idle(20, 1'b1);
        check_single("single");

        // Backpressure with stray rd_data_valid pulses in IDLE and while BEAT0 is held.
        clear_logs();
        junk_pct = 100;
        step(1'b1, 13'h0005, 24'h00A53C, 1'b0);
        wait_beat(1, 1'b0);
        run_idle(3, 1'b0);
        begin
            logic pat[6];
            pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 0; pat[5] = 1;
            for (int i = 0; i < 6; i++) step(1'b0, 13'h0, 24'h0, pat[i]);
        end
        run_idle(10, 1'b1);
        check_single("bp");

        // Queue fill: 5 back-to-back reads with the transmit side stalled.
        junk_pct = 20; fixed_lat = -1; force_data = 1'b0;
        clear_logs();
        for (int i = 1; i <= 5; i++) step(1'b1, 13'($urandom), {16'($urandom), 8'(i)}, 1'b0);
        run_idle(8, 1'b0);
        run_idle(60, 1'b1);
        chk("fill_count", 64'(tag_log.size()), 64'd5);
        for (int i = 0; i < 5 && i < tag_log.size(); i++) chk("fill_tag", 64'(tag_log[i]), 64'(i + 1));

        // Overflow drop: the sixth request is lost and overflow stays set.
        clear_logs();
        for (int i = 0; i < 6; i++) step(1'b1, 13'($urandom), {16'($urandom), 8'(8'd11 + 8'(i))}, 1'b0);
        run_idle(8, 1'b0);
        run_idle(60, 1'b1);
        chk("drop_count", 64'(tag_log.size()), 64'd5);
        for (int i = 0; i < 5 && i < tag_log.size(); i++) chk("drop_tag", 64'(tag_log[i]), 64'(11 + i));
        chk("drop_ovf", overflow, 1);
        run_idle(10, 1'b1);
        chk("drop_ovf_sticky", overflow, 1);
        do_reset();

        // Reset while BEAT1 is on the bus; nothing may leak out afterwards.
        completer_id = 16'h0100; force_data = 1'b1; fixed_lat = 1;
        step(1'b1, 13'h0005, 24'h00A53C, 1'b0);
        wait_beat(1, 1'b0);
        step(1'b0, 13'h0, 24'h0, 1'b1);
        step(1'b0, 13'h0, 24'h0, 1'b0);
        do_reset();
        clear_logs();
        run_idle(10, 1'b1);
        chk("rst_no_residue", 64'(acc_d.size()), 64'd0);
        step(1'b1, 13'h0005, 24'h00A53C, 1'b1);
        run_idle(20, 1'b1);
        check_single("post_rst");

        // Random traffic, random latency and backpressure, stray data-valid pulses.
        completer_id = 16'($urandom); force_data = 1'b0; fixed_lat = -1; junk_pct = 15;
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) == 0, 13'($urandom), 24'($urandom), $urandom_range(0, 3) != 0);
        run_idle(100, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
